phy_lane_par: RTL and testbench
===============================

PHY_LANE_PAR -- requirements
Module: phy_lane_par

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits per lane (WIDTH >= 4).
REQ-002 Parameter LANES, default 2: number of independent serial lanes.
REQ-003 Parameter IDLE, default 8'hBC (WIDTH bits): idle/comma word sent when no valid data.
REQ-004 Parameter SYNC_COUNT, default 4: consecutive aligned IDLE words required for lock (1..15).
REQ-005 clk_8f  input  1: single bit clock; all state updates on its rising edge.
REQ-006 reset  input  1: asynchronous, active-low reset; 0 resets all state immediately.
REQ-007 data_in  input  LANES*WIDTH: parallel TX words, lane k at bits [k*WIDTH +: WIDTH].
REQ-008 valid_in  input  LANES: per-lane TX word valid.
REQ-009 serial_out  output  LANES: per-lane serial bit stream, MSB first.
REQ-010 data_out  output  LANES*WIDTH: parallel RX words, same packing as data_in.
REQ-011 valid_out  output  LANES: per-lane RX word valid.
REQ-012 active  output  LANES: per-lane RX lock indicator.

Function
REQ-013 TX and RX of each lane SHALL be connected by internal loopback: RX lane k input = serial_out[k].
REQ-014 A shared TX bit counter tx_cnt SHALL count 0..WIDTH-1 and wrap to 0.
REQ-015 On the edge where tx_cnt == WIDTH-1, each lane TX shift register SHALL load data_in lane k if valid_in[k]=1, else IDLE.
REQ-016 On all other edges the TX shift register SHALL shift left one bit; serial_out[k] = register MSB.
REQ-017 data_in/valid_in SHALL be sampled only on the load edge; changes at other times have no effect.
REQ-018 Each RX lane SHALL shift serial input into a WIDTH-bit shift register every edge (LSB in).
REQ-019 Each RX lane SHALL run FSM states SEARCH, SYNC, LOCKED plus its own word counter rx_cnt (0..WIDTH-1).
REQ-020 SEARCH: shift register compared to IDLE every edge, bit-aligned; on match -> SYNC, rx_cnt := 0, idle_cnt := 1.
REQ-021 SYNC: at each word boundary (rx_cnt == WIDTH-1 after shift) word == IDLE increments idle_cnt; idle_cnt reaching SYNC_COUNT -> LOCKED; any non-IDLE word -> SEARCH, idle_cnt := 0.
REQ-022 LOCKED: active[k]=1; at each word boundary data_out lane k := word and valid_out[k] := (word != IDLE), held until next boundary.
REQ-023 In states SEARCH/SYNC: active, valid_out = 0 and data_out = 0.
REQ-024 Once LOCKED, a lane SHALL stay LOCKED until reset (no loss-of-lock detection).
REQ-025 A valid TX word equal to IDLE SHALL be delivered with valid_out=0 (documented limitation).
REQ-026 Latency: a word sampled on a load edge SHALL appear on data_out exactly WIDTH+1 edges later, identical for all lanes.
REQ-027 Lanes SHALL be fully independent; one lane's data never affects another lane's FSM.
REQ-028 SYNC_COUNT=1 SHALL enter LOCKED on the first SEARCH match.

Reset
REQ-029 While reset=0: tx_cnt=0, TX/RX shift registers=0, FSMs=SEARCH, idle_cnt=0, serial_out=0, data_out=0, valid_out=0, active=0.
REQ-030 Reset asserted mid-word or in LOCKED SHALL clear all state asynchronously; after release, lock is re-acquired from SEARCH.
REQ-031 First TX load SHALL occur on the WIDTH-th rising edge after reset release.

Verification
REQ-032 Defaults, valid_in=0 after reset -> active=11 after 4 IDLE words acquired (within 6*8 edges of release), valid_out=00.
REQ-033 Locked, lane0 sends 8'h3A, 8'hF0 back-to-back, lane1 idle -> data_out lane0 3A then F0, valid_out[0]=1 for 16 edges, each WIDTH+1 edges after its load edge; lane1 valid=0.
REQ-034 Locked, valid_in[0]=1 with data 8'hBC -> valid_out[0]=0, data_out lane0=BC.
REQ-035 During SYNC (idle_cnt=2), inject valid word 8'h55 -> FSM returns to SEARCH, active stays 0, relocks after 4 more IDLEs.
REQ-036 reset pulled low while LOCKED mid-word -> all outputs 0 immediately; relock after release.
REQ-037 WIDTH=10, LANES=4, IDLE=10'h17C, SYNC_COUNT=2 -> all 4 lanes lock, word 10'h2A5 on lane3 returns unchanged with latency 11.

Source files
------------

// File: rtl/phy_lane_par.sv
// ============================================================================
// phy_lane_par : multi-lane serializer with looped-back comma-aligning
// deserializer.
// Rev 1.0
// ============================================================================
`default_nettype none

module phy_lane_par #(
  parameter int               WIDTH      = 8,
  parameter int               LANES      = 2,
  parameter logic [WIDTH-1:0] IDLE       = 8'hBC,
  parameter int               SYNC_COUNT = 4
) (
  input  logic                     clk_8f,
  input  logic                     reset,
  input  logic [LANES*WIDTH-1:0]   data_in,
  input  logic [LANES-1:0]         valid_in,
  output logic [LANES-1:0]         serial_out,
  output logic [LANES*WIDTH-1:0]   data_out,
  output logic [LANES-1:0]         valid_out,
  output logic [LANES-1:0]         active
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [3:0]     SC   = 4'(SYNC_COUNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          load;

  always_comb begin
    load     = (tx_cnt_q == LAST);
    tx_cnt_d = load ? '0 : tx_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) tx_cnt_q <= '0;
    else        tx_cnt_q <= tx_cnt_d;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    state_t           state_q, state_d;
    logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [3:0]       idle_cnt_q, idle_cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vout_q, vout_d;
    logic             act_q, act_d;
    logic             boundary;
    logic             word_idle;

    always_comb begin
      if (load) tx_sr_d = valid_in[k] ? data_in[k*WIDTH +: WIDTH] : IDLE;
      else      tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
    end

    assign serial_out[k] = tx_sr_q[WIDTH-1];

    // The FSM judges the already-registered RX word, which adds the one
    // extra edge of loopback latency on top of the WIDTH shift edges.
    always_comb begin
      rx_sr_d    = {rx_sr_q[WIDTH-2:0], serial_out[k]};
      boundary   = (rx_cnt_q == LAST);
      word_idle  = (rx_sr_q == IDLE);
      state_d    = state_q;
      rx_cnt_d   = boundary ? '0 : rx_cnt_q + 1'b1;
      idle_cnt_d = idle_cnt_q;
      dout_d     = dout_q;
      vout_d     = vout_q;
      act_d      = act_q;
      case (state_q)
        SEARCH: begin
          if (word_idle) begin
            rx_cnt_d   = '0;
            idle_cnt_d = 4'd1;
            if (SC == 4'd1) begin
              state_d = LOCKED;
              act_d   = 1'b1;
            end else begin
              state_d = SYNC;
            end
          end
        end
        SYNC: begin
          if (boundary) begin
            if (word_idle) begin
              idle_cnt_d = idle_cnt_q + 4'd1;
              if (idle_cnt_q + 4'd1 == SC) begin
                state_d = LOCKED;
                act_d   = 1'b1;
              end
            end else begin
              state_d    = SEARCH;
              idle_cnt_d = 4'd0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            dout_d = rx_sr_q;
            vout_d = !word_idle;
          end
        end
        default: begin
          state_d    = SEARCH;
          idle_cnt_d = 4'd0;
        end
      endcase
    end

    always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
        tx_sr_q    <= '0;
        rx_sr_q    <= '0;
        state_q    <= SEARCH;
        rx_cnt_q   <= '0;
        idle_cnt_q <= 4'd0;
        dout_q     <= '0;
        vout_q     <= 1'b0;
        act_q      <= 1'b0;
      end else begin
        tx_sr_q    <= tx_sr_d;
        rx_sr_q    <= rx_sr_d;
        state_q    <= state_d;
        rx_cnt_q   <= rx_cnt_d;
        idle_cnt_q <= idle_cnt_d;
        dout_q     <= dout_d;
        vout_q     <= vout_d;
        act_q      <= act_d;
      end
    end

    assign data_out[k*WIDTH +: WIDTH] = dout_q;
    assign valid_out[k]               = vout_q;
    assign active[k]                  = act_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_phy_lane_par.sv
// Bench for phy_lane_par: default 2x8 instance plus a 4x10 instance,
// scoreboard of expected RX words keyed by the edge they must appear on.
`default_nettype none

module tb_phy_lane_par;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in_a, data_out_a;
  logic [1:0]  valid_in_a, serial_out_a, valid_out_a, active_a;
  logic [39:0] data_in_b, data_out_b;
  logic [3:0]  valid_in_b, serial_out_b, valid_out_b, active_b;

  int edge_n;
  int cmp_n = 0;
  int bad_n = 0;

  typedef struct {
    int         cfg;
    int         lane;
    int         due;
    logic [9:0] data;
    logic       vld;
    logic [9:0] prev;
    logic       pvld;
  } exp_t;

  exp_t sb[$];

  phy_lane_par u_dut_a (
    .clk_8f     (clk),
    .reset      (reset),
    .data_in    (data_in_a),
    .valid_in   (valid_in_a),
    .serial_out (serial_out_a),
    .data_out   (data_out_a),
    .valid_out  (valid_out_a),
    .active     (active_a)
  );

  phy_lane_par #(
    .WIDTH      (10),
    .LANES      (4),
    .IDLE       (10'h17C),
    .SYNC_COUNT (2)
  ) u_dut_b (
    .clk_8f     (clk),
    .reset      (reset),
    .data_in    (data_in_b),
    .valid_in   (valid_in_b),
    .serial_out (serial_out_b),
    .data_out   (data_out_b),
    .valid_out  (valid_out_b),
    .active     (active_b)
  );

  always #5 clk = ~clk;

  // Edges since reset release: edge W, 2W, ... are the load edges.
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic wait_edge(input int n);
    if (edge_n > n) begin
      cmp_n++; bad_n++;
      $display("FAIL wait_edge: now at edge %0d, required edge %0d", edge_n, n);
    end
    while (edge_n < n) @(negedge clk);
  endtask

  function automatic void sample(input int cfg, input int lane,
                                 output logic [9:0] d, output logic v);
    if (cfg == 0) begin
      d = {2'b00, data_out_a[lane*8 +: 8]};
      v = valid_out_a[lane];
    end else begin
      d = data_out_b[lane*10 +: 10];
      v = valid_out_b[lane];
    end
  endfunction

  task automatic send(input int cfg, input int lane, input logic [9:0] d,
                      input logic v, input logic [9:0] pd, input logic pv);
    int         w;
    logic [9:0] idle;
    exp_t       e;
    w    = (cfg == 0) ? 8 : 10;
    idle = (cfg == 0) ? 10'h0BC : 10'h17C;
    while (((edge_n + 1) % w) != 0) @(negedge clk);
    if (cfg == 0) begin
      data_in_a[lane*8 +: 8] = d[7:0];
      valid_in_a[lane]       = v;
    end else begin
      data_in_b[lane*10 +: 10] = d;
      valid_in_b[lane]         = v;
    end
    e.cfg  = cfg;
    e.lane = lane;
    e.due  = edge_n + 1 + w + 1;
    e.data = v ? d : idle;
    e.vld  = v && (d != idle);
    e.prev = pd;
    e.pvld = pv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    data_in_a = '0; valid_in_a = '0;
    data_in_b = '0; valid_in_b = '0;
    @(negedge clk);
  endtask

  task automatic drain();
    exp_t       e;
    logic [9:0] gd;
    logic       gv;
    int         w;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      w = (e.cfg == 0) ? 8 : 10;
      wait_edge(e.due - 1);
      sample(e.cfg, e.lane, gd, gv);
      cmp_n++;
      if (gd !== e.prev || gv !== e.pvld) begin
        bad_n++;
        $display("FAIL early cfg%0d lane%0d edge %0d: got %h/%b required %h/%b",
                 e.cfg, e.lane, edge_n, gd, gv, e.prev, e.pvld);
      end
      wait_edge(e.due);
      sample(e.cfg, e.lane, gd, gv);
      cmp_n++;
      if (gd !== e.data || gv !== e.vld) begin
        bad_n++;
        $display("FAIL word cfg%0d lane%0d edge %0d: got %h/%b required %h/%b",
                 e.cfg, e.lane, edge_n, gd, gv, e.data, e.vld);
      end
      wait_edge(e.due + w - 1);
      sample(e.cfg, e.lane, gd, gv);
      cmp_n++;
      if (gd !== e.data || gv !== e.vld) begin
        bad_n++;
        $display("FAIL hold cfg%0d lane%0d edge %0d: got %h/%b required %h/%b",
                 e.cfg, e.lane, edge_n, gd, gv, e.data, e.vld);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_in_a = '0; valid_in_a = '0;
    data_in_b = '0; valid_in_b = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    cmp_n++;
    if ({serial_out_a, data_out_a, valid_out_a, active_a} !== 22'd0) begin
      bad_n++;
      $display("FAIL reset_a: got %h required 0",
               {serial_out_a, data_out_a, valid_out_a, active_a});
    end
    cmp_n++;
    if ({serial_out_b, data_out_b, valid_out_b, active_b} !== 52'd0) begin
      bad_n++;
      $display("FAIL reset_b: got %h required 0",
               {serial_out_b, data_out_b, valid_out_b, active_b});
    end
    reset = 1'b1;
  endtask

  task automatic test_lock();
    wait_edge(7);
    cmp_n++;
    if (serial_out_a !== 2'b00) begin
      bad_n++; $display("FAIL pre_load_serial: got %b required 00", serial_out_a);
    end
    wait_edge(8);
    cmp_n++;
    if (serial_out_a !== 2'b11) begin
      bad_n++; $display("FAIL first_load_serial: got %b required 11", serial_out_a);
    end
    wait_edge(30);
    cmp_n++;
    if (active_b !== 4'h0) begin
      bad_n++; $display("FAIL lock_b_early: got %h required 0", active_b);
    end
    wait_edge(31);
    cmp_n++;
    if (active_b !== 4'hF) begin
      bad_n++; $display("FAIL lock_b: got %h required f", active_b);
    end
    wait_edge(40);
    cmp_n++;
    if (active_a !== 2'b00) begin
      bad_n++; $display("FAIL lock_a_early: got %b required 00", active_a);
    end
    wait_edge(41);
    cmp_n++;
    if (active_a !== 2'b11) begin
      bad_n++; $display("FAIL lock_a: got %b required 11", active_a);
    end
    wait_edge(48);
    cmp_n++;
    if (valid_out_a !== 2'b00) begin
      bad_n++; $display("FAIL idle_valid: got %b required 00", valid_out_a);
    end
  endtask

  task automatic test_back_to_back();
    send(0, 0, 10'h03A, 1'b1, 10'h0BC, 1'b0);
    send(0, 0, 10'h0F0, 1'b1, 10'h03A, 1'b1);
    drain();
    cmp_n++;
    if (valid_out_a[1] !== 1'b0 || data_out_a[15:8] !== 8'hBC) begin
      bad_n++;
      $display("FAIL lane1_quiet: got %h/%b required bc/0", data_out_a[15:8], valid_out_a[1]);
    end
    wait_edge(edge_n + 1);
    cmp_n++;
    if (valid_out_a !== 2'b00 || data_out_a !== 16'hBCBC) begin
      bad_n++;
      $display("FAIL back_to_idle: got %h/%b required bcbc/00", data_out_a, valid_out_a);
    end
  endtask

  task automatic test_idle_data();
    send(0, 0, 10'h0BC, 1'b1, 10'h0BC, 1'b0);
    drain();
  endtask

  task automatic test_sample_only();
    while ((edge_n % 8) != 2) @(negedge clk);
    data_in_a[7:0] = 8'h77;
    valid_in_a[0]  = 1'b1;
    repeat (3) @(negedge clk);
    data_in_a = '0; valid_in_a = '0;
    send(0, 0, 10'h000, 1'b0, 10'h0BC, 1'b0);
    drain();
  endtask

  task automatic test_wide();
    send(1, 3, 10'h2A5, 1'b1, 10'h17C, 1'b0);
    drain();
    cmp_n++;
    if (valid_out_b[2:0] !== 3'b000) begin
      bad_n++; $display("FAIL wide_others: got %b required 000", valid_out_b[2:0]);
    end
  endtask

  task automatic test_sync_abort();
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    wait_edge(23);
    data_in_a[7:0] = 8'h55;
    valid_in_a[0]  = 1'b1;
    @(posedge clk);
    #1 data_in_a = '0; valid_in_a = '0;
    wait_edge(25);
    cmp_n++;
    if (active_a !== 2'b00) begin
      bad_n++; $display("FAIL sync_inactive: got %b required 00", active_a);
    end
    wait_edge(33);
    cmp_n++;
    if (active_a[0] !== 1'b0 || valid_out_a[0] !== 1'b0 || data_out_a[7:0] !== 8'h00) begin
      bad_n++;
      $display("FAIL abort_outputs: got %b/%b/%h required 0/0/00",
               active_a[0], valid_out_a[0], data_out_a[7:0]);
    end
    wait_edge(41);
    cmp_n++;
    if (active_a !== 2'b10) begin
      bad_n++; $display("FAIL lane_independent: got %b required 10", active_a);
    end
    wait_edge(64);
    cmp_n++;
    if (active_a !== 2'b10) begin
      bad_n++; $display("FAIL relock_early: got %b required 10", active_a);
    end
    wait_edge(65);
    cmp_n++;
    if (active_a !== 2'b11) begin
      bad_n++; $display("FAIL relock: got %b required 11", active_a);
    end
  endtask

  task automatic test_reset_locked();
    wait_edge(75);
    cmp_n++;
    if (data_out_a !== 16'hBCBC || valid_out_a !== 2'b00) begin
      bad_n++;
      $display("FAIL locked_idle: got %h/%b required bcbc/00", data_out_a, valid_out_a);
    end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    cmp_n++;
    if ({serial_out_a, data_out_a, valid_out_a, active_a, active_b} !== 26'd0) begin
      bad_n++;
      $display("FAIL async_reset: got %h required 0",
               {serial_out_a, data_out_a, valid_out_a, active_a, active_b});
    end
    @(negedge clk) reset = 1'b1;
    wait_edge(31);
    cmp_n++;
    if (active_b !== 4'hF) begin
      bad_n++; $display("FAIL relock_b: got %h required f", active_b);
    end
    wait_edge(40);
    cmp_n++;
    if (active_a !== 2'b00) begin
      bad_n++; $display("FAIL relock_a_early: got %b required 00", active_a);
    end
    wait_edge(41);
    cmp_n++;
    if (active_a !== 2'b11) begin
      bad_n++; $display("FAIL relock_a: got %b required 11", active_a);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_back_to_back();
    test_idle_data();
    test_sample_only();
    test_wide();
    test_sync_abort();
    test_reset_locked();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
